alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 8-bit accumulator ALU in the datapath.
- Keeps the add/sub/logic/load op set and the 4-bit flag register.
- Adds shift operations (one bit per cycle) and an unsigned iterative shift-add multiplier with a double-width result.
- Sits between the control unit (which issues start/op/operand) and the register file; the control unit stalls on busy and advances on done.

Parameters:
- WIDTH, 8: datapath width in bits; must be ≥4 and a power of 2.
- SH_BITS, $clog2(WIDTH): width of the shift-count field, taken from operand[SH_BITS-1:0].

Ports:
- clk  in  1  rising-edge clock.
- arst  in  1  reset; synchronous, active-high.
- start  in  1  issue strobe; sampled only when busy=0.
- op  in  4  opcode, sampled with start.
- operand  in  WIDTH  second operand (from MBR or IBR), sampled with start.
- acc  out  WIDTH  accumulator (low result).
- acc_hi  out  WIDTH  high half of the product; written only by MUL.
- flags  out  4  bit0 CARRY, bit1 OV, bit2 ZERO, bit3 NEG.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse when the result is committed.

Behaviour:
- Reset (arst=1 at clk edge): acc=0, acc_hi=0, flags=0, busy=0, done=0, state=IDLE. Reset aborts any op in flight with no done pulse. Reset wins over start.
- Opcodes:
  - 0 ADD, 1 ADDC, 2 SUB, 3 SUBC
  - 4 NOR, 5 NAND, 6 XOR, 7 XNOR
  - 8 LOAD
  - 9 SHL, 10 SHR, 11 ASR
  - 12 MUL
  - 13–15 NOP: commits with no change and still pulses done.
- Timing: cycle C0 is the cycle where start=1 and busy=0, sampled at edge E0. done is high in the cycle after the committing edge.
- Single-cycle ops (0–8, 13–15): commit on E0; done=1 in C1; busy stays 0.
- Add/sub arithmetic uses WIDTH+1-bit results.
  - ADD/ADDC: {c,r}=acc+operand(+CARRY). CARRY=carry-out.
  - SUB/SUBC: {c,r}=acc-operand(-CARRY). CARRY=borrow.
  - OV=signed overflow. Add: operands have the same sign and r's sign differs. Sub: operand signs differ and r's sign differs from acc.
  - ZERO=(r==0); NEG=r[WIDTH-1].
- Logic ops: acc=result; ZERO and NEG updated; CARRY and OV preserved.
- LOAD: acc=operand; all flags preserved.
- Shifts: n=operand[SH_BITS-1:0].
  - E0 captures acc into a work register and n into a counter, state→SHIFT, busy=1.
  - Edges E1..En each shift one bit; the last shift commits. done in C(n+1); busy high C1..Cn.
  - n=0: commits on E0 with acc unchanged; CARRY preserved; ZERO and NEG recomputed.
  - SHL: zero fill in. SHR: zero fill in. ASR: msb replicated.
  - CARRY=last bit shifted out; ZERO and NEG from the final value; OV preserved.
- MUL (unsigned):
  - E0 captures multiplicand=acc and multiplier=operand, clears the product, state→MUL.
  - Edges E1..E_WIDTH each perform one shift-add step; E_WIDTH commits {acc_hi,acc}=product.
  - done in C(WIDTH+1); busy high C1..C_WIDTH.
  - Flags: CARRY=(acc_hi!=0); ZERO=(2·WIDTH-bit product==0); NEG=product[2·WIDTH-1]; OV preserved.
- acc, acc_hi and flags change only on the commit edge. Intermediate values are internal and never visible.
- start with busy=1 is ignored, with no queuing. start in a done cycle (busy=0) is accepted, so back-to-back issue is allowed.
- State machine:
  - IDLE→SHIFT when start, shift op and n≥0... specifically n≠0.
  - IDLE→MUL when start and op=12.
  - SHIFT→IDLE when the counter reaches 0.
  - MUL→IDLE after WIDTH steps.
  - Any state→IDLE on arst.
- done is registered, high exactly one cycle per accepted op.

Test Plan:
- Reset, then LOAD 0x7F followed by ADD 0x01 → acc=0x80, flags OV=1, NEG=1, CARRY=0, ZERO=0; done in C1; busy never 1.
- LOAD 0x00 then SUB 0x01 → acc=0xFF, CARRY=1, NEG=1, OV=0. Then SUBC 0x00 → acc=0xFE, CARRY=0.
- LOAD 0x81 then SHL with operand=3 → busy high C1–C3; acc=0x08 and done only in C4; CARRY=0. Repeat with ASR n=1 on 0x81 → acc=0xC0, CARRY=1.
- LOAD 0xFF then MUL 0xFF (WIDTH=8) → busy C1–C8; done in C9; acc_hi=0xFE, acc=0x01, CARRY=1, ZERO=0. start pulsed at C3 is ignored.
- MUL in flight, arst asserted at C4 → next cycle acc=0, acc_hi=0, flags=0, busy=0; no done pulse ever.
- Back-to-back: ADD issued in the done cycle of a MUL → accepted; done again in the following cycle; acc_hi unchanged by the ADD.

Source files
------------

// File: rtl/alu_seq_if.sv
// Control-unit <-> ALU bundle: issue strobe, opcode, operand and the result/status lines.
// Latency: none (wires only).
// Backpressure: control unit holds off issuing while busy is high; done marks each commit.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_hi;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    // Control unit side: issues ops, observes results.
    modport master (
        output start, op, operand,
        input  acc, acc_hi, flags, busy, done
    );

    // ALU side.
    modport slave (
        input  start, op, operand,
        output acc, acc_hi, flags, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle accumulator ALU: add/sub/logic/load, bit-serial shifts, iterative unsigned multiply.
// Latency: 1 cycle for simple ops, n+1 for an n-bit shift, WIDTH+1 for MUL (done in the cycle after commit).
// Backpressure: start is ignored while busy; no queuing, back-to-back issue allowed in the done cycle.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SH_BITS = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      arst,
    alu_seq_if.slave bus
);
    localparam int CW = SH_BITS + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_ASR  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc_r, acc_hi_r, work, mplier;
    logic [2*WIDTH-1:0] mcand, prod;
    logic [3:0]         flags_r;
    logic               busy_r, done_r;
    logic [CW-1:0]      cnt;
    logic [1:0]         sh_kind;

    logic [WIDTH:0]     addsub;
    logic [WIDTH-1:0]   sc_acc;
    logic [3:0]         sc_flags;
    logic               upd_zn;
    logic               is_shift, is_mul;
    logic [SH_BITS-1:0] n;
    logic [WIDTH-1:0]   work_nx;
    logic               sh_out;
    logic [2*WIDTH-1:0] prod_nx;

    assign bus.acc    = acc_r;
    assign bus.acc_hi = acc_hi_r;
    assign bus.flags  = flags_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

    // Result of an op that commits on its issue edge (also zero-length shifts).
    always_comb begin
        sc_acc   = acc_r;
        sc_flags = flags_r;
        addsub   = '0;
        upd_zn   = 1'b1;
        n        = bus.operand[SH_BITS-1:0];
        is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_ASR);
        is_mul   = (bus.op == OP_MUL);
        case (bus.op)
            OP_ADD, OP_ADDC: begin
                addsub = {1'b0, acc_r} + {1'b0, bus.operand}
                       + {{WIDTH{1'b0}}, (bus.op == OP_ADDC) & flags_r[0]};
                sc_acc      = addsub[WIDTH-1:0];
                sc_flags[0] = addsub[WIDTH];
                sc_flags[1] = (acc_r[WIDTH-1] == bus.operand[WIDTH-1])
                            && (addsub[WIDTH-1] != acc_r[WIDTH-1]);
            end
            OP_SUB, OP_SUBC: begin
                // Bit WIDTH of the widened difference is the borrow.
                addsub = {1'b0, acc_r} - {1'b0, bus.operand}
                       - {{WIDTH{1'b0}}, (bus.op == OP_SUBC) & flags_r[0]};
                sc_acc      = addsub[WIDTH-1:0];
                sc_flags[0] = addsub[WIDTH];
                sc_flags[1] = (acc_r[WIDTH-1] != bus.operand[WIDTH-1])
                            && (addsub[WIDTH-1] != acc_r[WIDTH-1]);
            end
            OP_NOR:  sc_acc = ~(acc_r | bus.operand);
            OP_NAND: sc_acc = ~(acc_r & bus.operand);
            OP_XOR:  sc_acc = acc_r ^ bus.operand;
            OP_XNOR: sc_acc = ~(acc_r ^ bus.operand);
            OP_LOAD: begin
                sc_acc = bus.operand;
                upd_zn = 1'b0;
            end
            OP_SHL, OP_SHR, OP_ASR: sc_acc = acc_r;
            default: upd_zn = 1'b0;
        endcase
        if (upd_zn) begin
            sc_flags[2] = (sc_acc == '0);
            sc_flags[3] = sc_acc[WIDTH-1];
        end
    end

    // One-bit shift step and one shift-add multiply step.
    always_comb begin
        case (sh_kind)
            2'b01: begin
                work_nx = {work[WIDTH-2:0], 1'b0};
                sh_out  = work[WIDTH-1];
            end
            2'b10: begin
                work_nx = {1'b0, work[WIDTH-1:1]};
                sh_out  = work[0];
            end
            default: begin
                work_nx = {work[WIDTH-1], work[WIDTH-1:1]};
                sh_out  = work[0];
            end
        endcase
        prod_nx = prod + (mplier[0] ? mcand : '0);
    end

    // Control FSM and architectural registers; results land only on the commit edge.
    always_ff @(posedge clk) begin
        if (arst) begin
            state    <= IDLE;
            acc_r    <= '0;
            acc_hi_r <= '0;
            flags_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            work     <= '0;
            mplier   <= '0;
            mcand    <= '0;
            prod     <= '0;
            cnt      <= '0;
            sh_kind  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_mul) begin
                            mcand  <= {{WIDTH{1'b0}}, acc_r};
                            mplier <= bus.operand;
                            prod   <= '0;
                            cnt    <= CW'(WIDTH);
                            busy_r <= 1'b1;
                            state  <= MUL;
                        end else if (is_shift && (n != '0)) begin
                            work    <= acc_r;
                            cnt     <= {1'b0, n};
                            sh_kind <= bus.op[1:0];
                            busy_r  <= 1'b1;
                            state   <= SHIFT;
                        end else begin
                            acc_r   <= sc_acc;
                            flags_r <= sc_flags;
                            done_r  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_nx;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        acc_r   <= work_nx;
                        flags_r <= {work_nx[WIDTH-1], (work_nx == '0), flags_r[1], sh_out};
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                MUL: begin
                    prod   <= prod_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        acc_r    <= prod_nx[WIDTH-1:0];
                        acc_hi_r <= prod_nx[2*WIDTH-1:WIDTH];
                        flags_r  <= {prod_nx[2*WIDTH-1], (prod_nx == '0), flags_r[1],
                                     (prod_nx[2*WIDTH-1:WIDTH] != '0)};
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8) with a reference model feeding a scoreboard.
// Latency: checks done cycle and busy cycle count of every op.
// Backpressure: exercises ignored start while busy and issue in the done cycle.
module tb_alu_seq;
    localparam int W = 8;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] hi;
        logic [3:0] fl;
        int         lat;
        int         bsy;
    } exp_t;

    logic clk;
    logic arst;
    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];

    logic [7:0] m_acc, m_hi;
    logic [3:0] m_flags;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: predicts the committed state and timing of one op, pushes it.
    task automatic predict(input logic [3:0] o, input logic [7:0] v);
        exp_t       e;
        int         s;
        int         cnt;
        logic [7:0] r;
        logic [15:0] p;
        logic       c, ov, z, ng, upd;
        e.lat = 1; e.bsy = 0;
        r = m_acc; c = m_flags[0]; ov = m_flags[1]; z = m_flags[2]; ng = m_flags[3];
        upd = 1'b1;
        case (o)
            4'd0, 4'd1: begin
                s = m_acc + v + ((o == 4'd1 && m_flags[0]) ? 1 : 0);
                r = s[7:0]; c = (s > 255);
                ov = (m_acc[7] == v[7]) && (r[7] != m_acc[7]);
            end
            4'd2, 4'd3: begin
                s = m_acc - v - ((o == 4'd3 && m_flags[0]) ? 1 : 0);
                r = s[7:0]; c = (s < 0);
                ov = (m_acc[7] != v[7]) && (r[7] != m_acc[7]);
            end
            4'd4: r = ~(m_acc | v);
            4'd5: r = ~(m_acc & v);
            4'd6: r = m_acc ^ v;
            4'd7: r = ~(m_acc ^ v);
            4'd8: begin r = v; upd = 1'b0; end
            4'd9, 4'd10, 4'd11: begin
                cnt = int'(v[2:0]);
                for (int i = 0; i < cnt; i++) begin
                    if (o == 4'd9) begin c = r[7]; r = r << 1; end
                    else if (o == 4'd10) begin c = r[0]; r = r >> 1; end
                    else begin c = r[0]; r = {r[7], r[7:1]}; end
                end
                if (cnt != 0) begin e.lat = cnt + 1; e.bsy = cnt; end
            end
            4'd12: begin
                p = m_acc * v;
                m_hi = p[15:8]; r = p[7:0];
                c = (p[15:8] != 8'h00); z = (p == 16'h0); ng = p[15];
                upd = 1'b0; e.lat = 9; e.bsy = 8;
            end
            default: upd = 1'b0;
        endcase
        if (upd) begin z = (r == 8'h00); ng = r[7]; end
        m_acc = r;
        m_flags = {ng, z, ov, c};
        e.acc = m_acc; e.hi = m_hi; e.fl = m_flags;
        sb.push_back(e);
    endtask

    // Issue one op at the current negedge, watch until done, compare against the scoreboard.
    // ign_at > 0 pulses a stray LOAD start in that cycle (must be ignored while busy).
    task automatic run_op(input logic [3:0] o, input logic [7:0] v, input int ign_at);
        exp_t e;
        int   k, bc;
        bit   seen;
        predict(o, v);
        bus.start = 1'b1; bus.op = o; bus.operand = v;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1; bc = 0; seen = 0;
        while (k <= 40) begin
            if (bus.done === 1'b1) begin seen = 1; break; end
            if (bus.busy === 1'b1) bc++;
            if (k == ign_at) begin bus.start = 1'b1; bus.op = 4'd8; bus.operand = 8'h55; end
            @(negedge clk);
            bus.start = 1'b0;
            k++;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL op%0d timeout: done never seen within %0d cycles", o, k);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            vectors += 5;
            if (k !== e.lat) begin errors++; $display("FAIL op%0d latency: got C%0d want C%0d", o, k, e.lat); end
            if (bc !== e.bsy) begin errors++; $display("FAIL op%0d busy cycles: got %0d want %0d", o, bc, e.bsy); end
            if (bus.acc !== e.acc) begin errors++; $display("FAIL op%0d acc: got %h want %h", o, bus.acc, e.acc); end
            if (bus.acc_hi !== e.hi) begin errors++; $display("FAIL op%0d acc_hi: got %h want %h", o, bus.acc_hi, e.hi); end
            if (bus.flags !== e.fl) begin errors++; $display("FAIL op%0d flags: got %b want %b", o, bus.flags, e.fl); end
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; bus.start = 1'b0; bus.op = 4'd0; bus.operand = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.acc, bus.acc_hi, bus.flags, bus.busy, bus.done} !== 22'h0) begin
            errors++;
            $display("FAIL reset state: got acc=%h hi=%h fl=%b busy=%b done=%b want all zero",
                     bus.acc, bus.acc_hi, bus.flags, bus.busy, bus.done);
        end
        arst = 1'b0;
        m_acc = 8'h00; m_hi = 8'h00; m_flags = 4'h0;
    endtask

    task automatic test_add_ov();
        run_op(4'd8, 8'h7F, 0);
        run_op(4'd0, 8'h01, 0);
        vectors++;
        if ({bus.acc, bus.flags} !== {8'h80, 4'b1010}) begin
            errors++; $display("FAIL add_ov: got acc=%h fl=%b want acc=80 fl=1010", bus.acc, bus.flags);
        end
    endtask

    task automatic test_sub();
        run_op(4'd8, 8'h00, 0);
        run_op(4'd2, 8'h01, 0);
        vectors++;
        if ({bus.acc, bus.flags} !== {8'hFF, 4'b1001}) begin
            errors++; $display("FAIL sub: got acc=%h fl=%b want acc=ff fl=1001", bus.acc, bus.flags);
        end
        run_op(4'd3, 8'h00, 0);
        vectors++;
        if ({bus.acc, bus.flags[0]} !== {8'hFE, 1'b0}) begin
            errors++; $display("FAIL subc: got acc=%h c=%b want acc=fe c=0", bus.acc, bus.flags[0]);
        end
    endtask

    task automatic test_shift();
        run_op(4'd8, 8'h81, 0);
        run_op(4'd9, 8'h03, 0);
        vectors++;
        if ({bus.acc, bus.flags[0]} !== {8'h08, 1'b0}) begin
            errors++; $display("FAIL shl3: got acc=%h c=%b want acc=08 c=0", bus.acc, bus.flags[0]);
        end
        run_op(4'd8, 8'h81, 0);
        run_op(4'd11, 8'h01, 0);
        vectors++;
        if ({bus.acc, bus.flags[0]} !== {8'hC0, 1'b1}) begin
            errors++; $display("FAIL asr1: got acc=%h c=%b want acc=c0 c=1", bus.acc, bus.flags[0]);
        end
        run_op(4'd10, 8'h00, 0);
        run_op(4'd10, 8'h07, 0);
    endtask

    task automatic test_mul();
        run_op(4'd8, 8'hFF, 0);
        run_op(4'd12, 8'hFF, 3);
        vectors++;
        if ({bus.acc_hi, bus.acc, bus.flags[2], bus.flags[0]} !== {8'hFE, 8'h01, 1'b0, 1'b1}) begin
            errors++; $display("FAIL mul_ff: got hi=%h acc=%h z=%b c=%b want fe 01 0 1",
                               bus.acc_hi, bus.acc, bus.flags[2], bus.flags[0]);
        end
        @(negedge clk);
        vectors++;
        if ({bus.done, bus.acc} !== {1'b0, 8'h01}) begin
            errors++; $display("FAIL mul_after: got done=%b acc=%h want 0 01", bus.done, bus.acc);
        end
    endtask

    task automatic test_mul_reset();
        int dn;
        run_op(4'd8, 8'h12, 0);
        bus.start = 1'b1; bus.op = 4'd12; bus.operand = 8'h34;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.acc, bus.acc_hi, bus.flags, bus.busy, bus.done} !== 22'h0) begin
            errors++;
            $display("FAIL mul_abort: got acc=%h hi=%h fl=%b busy=%b done=%b want all zero",
                     bus.acc, bus.acc_hi, bus.flags, bus.busy, bus.done);
        end
        arst = 1'b0;
        m_acc = 8'h00; m_hi = 8'h00; m_flags = 4'h0;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        vectors++;
        if (dn !== 0) begin errors++; $display("FAIL mul_abort_done: got %0d done pulses want 0", dn); end
    endtask

    task automatic test_back_to_back();
        run_op(4'd8, 8'h10, 0);
        run_op(4'd12, 8'h20, 0);
        run_op(4'd0, 8'h05, 0);
        vectors++;
        if ({bus.acc_hi, bus.acc} !== {8'h02, 8'h05}) begin
            errors++; $display("FAIL b2b: got hi=%h acc=%h want 02 05", bus.acc_hi, bus.acc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_add_ov();
        test_sub();
        test_shift();
        test_mul();
        test_mul_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
